// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch sequencer with a small circular prefetch
// buffer sitting between an asynchronous-read instruction memory and decode.
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (fetch address bounds and
// alignment checking with a FAULT state). Without it, FAULT is unreachable
// and fault/fault_pc are tied low.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd256,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned PW = (DEPTH <= 2) ? 1 : (DEPTH <= 4) ? 2 : 3;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     buf_pc    [DEPTH];
  logic [31:0]     buf_instr [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic            pop;
  logic            do_pop;
  logic            full;
  logic            push_slot;
  logic            push;
  logic            fault_hit;
  logic [31:0]     redir_target;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) next_ptr = '0;
    else                     next_ptr = p + PW'(1);
  endfunction

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_instr = buf_instr[head];
  assign out_pc    = buf_pc[head];
  assign busy      = (state != IDLE);

  // Handshake and push/pop qualification; a redirect cancels both.
  always_comb begin
    pop       = out_valid && out_ready;
    do_pop    = pop && !redirect_valid;
    full      = (count == CW'(DEPTH));
    push_slot = (state == FETCH) && !redirect_valid && (!full || pop);
`ifdef FETCH_BOUNDS_CHECK_EN
    if ((pc[31:10] == '0) && (pc[1:0] == 2'b00)) begin
      push      = push_slot;
      fault_hit = 1'b0;
    end else begin
      push      = 1'b0;
      fault_hit = push_slot;
    end
    redir_target = redirect_pc;
`else
    push         = push_slot;
    fault_hit    = 1'b0;
    redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif
  end

  // Sequencer state, PC and prefetch buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else begin
      case (state)
        IDLE:    if (start)          state <= FETCH;
        FETCH:   if (fault_hit)      state <= FAULT;
        FAULT:   if (redirect_valid) state <= FETCH;
        default:                     state <= IDLE;
      endcase

      if (redirect_valid) begin
        pc    <= redir_target;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          buf_pc[tail]    <= pc;
          buf_instr[tail] <= imem_data;
          tail            <= next_ptr(tail);
          pc              <= pc + 32'd4;
        end
        if (do_pop) head <= next_ptr(head);
        case ({push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  // Fault flag: set on a rejected fetch, cleared by the redirect out of FAULT.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (fault_hit) begin
      fault    <= 1'b1;
      fault_pc <= pc;
    end else if (redirect_valid && (state == FAULT)) begin
      fault    <= 1'b0;
    end
  end
`else
  assign fault    = 1'b0;
  assign fault_pc = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a scoreboard of expected
// delivered instructions, checked on every accepted handshake.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        busy;
  logic        fault;
  logic [31:0] fault_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  fetch_sequencer #(.RESET_PC(32'd256), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .busy           (busy),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  // Memory model: word equals its address below 1 KiB, zero above.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = (a < 32'd1024) ? a : 32'd0;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_push(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Scoreboard: every accepted handshake must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pop", out_pc, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b0;
    do_reset();

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_pc", fault_pc, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd256);

    // Streaming: 256, 260, 264 on consecutive cycles
    out_ready = 1'b1;
    expect_push(32'd256);
    expect_push(32'd260);
    start = 1'b1;
    step();
    start = 1'b0;
    check("lat_busy", {31'd0, busy}, 32'd1);
    check("lat_valid_e0", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_valid_e1", {31'd0, out_valid}, 32'd1);
    check("stream_pc0", out_pc, 32'd256);
    step();
    check("stream_pc1", out_pc, 32'd260);
    step();
    check("stream_pc2", out_pc, 32'd264);
    out_ready = 1'b0;
    check("sb_drained_1", sb.size(), 32'd0);

    // Backpressure: buffer fills, PC holds, then pop and push together
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("full_imem_addr", imem_addr, 32'd264);
    check("full_out_pc", out_pc, 32'd256);
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    expect_push(32'd256);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pp_out_pc", out_pc, 32'd260);
    check("pp_imem_addr", imem_addr, 32'd268);

    // Redirect with two buffered entries and ready high
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd512;
    step();
    redirect_valid = 1'b0;
    check("redir_valid_low", {31'd0, out_valid}, 32'd0);
    check("redir_imem_addr", imem_addr, 32'd512);
    expect_push(32'd512);
    step();
    check("redir_out_pc", out_pc, 32'd512);
    step();
    out_ready = 1'b0;
    check("redir_next_pc", out_pc, 32'd516);
    check("sb_drained_2", sb.size(), 32'd0);

    // Upper address bound: start and redirect together in IDLE
    do_reset();
    out_ready = 1'b1;
    start = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd1020;
    step();
    start = 1'b0;
    redirect_valid = 1'b0;
    check("bnd_imem_addr", imem_addr, 32'd1020);
    check("bnd_busy", {31'd0, busy}, 32'd1);
    expect_push(32'd1020);
    step();
    check("bnd_pc_1020", out_pc, 32'd1020);
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    check("flt_fault", {31'd0, fault}, 32'd1);
    check("flt_fault_pc", fault_pc, 32'd1024);
    check("flt_valid", {31'd0, out_valid}, 32'd0);
    check("flt_busy", {31'd0, busy}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'd256;
    step();
    redirect_valid = 1'b0;
    check("flt_cleared", {31'd0, fault}, 32'd0);
    check("flt_imem_addr", imem_addr, 32'd256);
    step();
    out_ready = 1'b0;
    check("flt_resume_pc", out_pc, 32'd256);
`else
    check("nof_pc_1024", out_pc, 32'd1024);
    check("nof_instr_zero", out_instr, 32'd0);
    expect_push(32'd1024);
    step();
    out_ready = 1'b0;
    check("nof_fault", {31'd0, fault}, 32'd0);
    check("nof_pc_1028", out_pc, 32'd1028);

    // Redirect target alignment is forced
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    check("align_imem_addr", imem_addr, 32'h0000_0200);

    // PC wraps modulo 2^32
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_imem_addr", imem_addr, 32'd0);
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
`endif
    check("sb_drained_3", sb.size(), 32'd0);

    // Reset mid-operation overrides start/redirect and empties the buffer
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_addr", imem_addr, 32'd264);
    rst = 1'b1;
    start = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'd512;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_imem_addr", imem_addr, 32'd256);
    check("mid_rst_out_pc", out_pc, 32'd0);
    step();
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
